// File: rtl/fft_output_serializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_output_serializer_if : frame-load / word-stream bus of the serializer
// Rev 1.0
// ---------------------------------------------------------------------------
interface fft_output_serializer_if #(
  parameter int p_outputBits = 32,
  parameter int p_points     = 32
);
  logic                             i_load;
  logic [p_points*p_outputBits-1:0] i_frame;
  logic                             i_ready;
  logic                             o_valid;
  logic [p_outputBits-1:0]          o_data;
  logic [4:0]                       o_index;
  logic                             o_last;
  logic                             o_busy;
  logic                             o_drop;

  // master: FFT stage / downstream sink side; slave: the serializer
  modport master (
    output i_load, i_frame, i_ready,
    input  o_valid, o_data, o_index, o_last, o_busy, o_drop
  );

  modport slave (
    input  i_load, i_frame, i_ready,
    output o_valid, o_data, o_index, o_last, o_busy, o_drop
  );
endinterface
`default_nettype wire

// File: rtl/fft_output_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_output_serializer : buffers a 32-word FFT frame and streams it out with
// valid/ready. Define FFT_BITREV_EN to emit words in bit-reversed order.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_output_serializer #(
  parameter int p_outputBits = 32,
  parameter int p_points     = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  fft_output_serializer_if.slave        bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [4:0]              n_q, n_d;
  logic                    drop_q, drop_d;
  logic [p_outputBits-1:0] buf_q [p_points];
  logic [p_outputBits-1:0] buf_d [p_points];
  logic                    capture;
  logic                    handshake;
  logic [4:0]              word_sel;

  assign handshake = (state_q == STREAM) && bus.i_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    drop_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_load) begin
          capture = 1'b1;
          n_d     = 5'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          n_d = n_q + 5'd1;
          if (n_q == 5'd31) state_d = IDLE;
        end
        // A new frame is only taken on the final handshake, giving no bubble
        if (bus.i_load) begin
          if (handshake && (n_q == 5'd31)) begin
            capture = 1'b1;
            n_d     = 5'd0;
            state_d = STREAM;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < p_points; k++) begin
      buf_d[k] = capture ? bus.i_frame[k*p_outputBits +: p_outputBits] : buf_q[k];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      n_q     <= 5'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      drop_q  <= drop_d;
    end
  end

  // Frame storage needs no reset: output is gated off outside STREAM
  always_ff @(posedge CLK) begin
    buf_q <= buf_d;
  end

`ifdef FFT_BITREV_EN
  assign word_sel = {n_q[0], n_q[1], n_q[2], n_q[3], n_q[4]};
`else
  assign word_sel = n_q;
`endif

  assign bus.o_valid = (state_q == STREAM);
  assign bus.o_busy  = (state_q == STREAM);
  assign bus.o_data  = (state_q == STREAM) ? buf_q[word_sel] : '0;
  assign bus.o_index = n_q;
  assign bus.o_last  = (state_q == STREAM) && (n_q == 5'd31);
  assign bus.o_drop  = drop_q;

endmodule
`default_nettype wire

// File: doc/fft_output_serializer.md
FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 SHALL have parameter p_outputBits, default 32: width of one complex result word, {real[31:16], imag[15:0]}.
REQ-002 SHALL have parameter p_points, default 32: number of words per frame; only 32 is supported.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_load, input, 1 bit: frame-present strobe from the final FFT stage.
REQ-006 SHALL have port i_frame, input, p_points*p_outputBits bits: the 32 stage outputs; word k occupies bits [32k+31:32k].
REQ-007 SHALL have port i_ready, input, 1 bit: downstream can accept a word.
REQ-008 SHALL have port o_valid, output, 1 bit: o_data holds a word.
REQ-009 SHALL have port o_data, output, p_outputBits bits: current output word.
REQ-010 SHALL have port o_index, output, 5 bits: output position n of o_data within the frame (0..31).
REQ-011 SHALL have port o_last, output, 1 bit: high when o_valid and o_index==31.
REQ-012 SHALL have port o_busy, output, 1 bit: high in the STREAM state.
REQ-013 SHALL have port o_drop, output, 1 bit: one-cycle pulse when an i_load is refused.

Function
REQ-014 SHALL implement two states: IDLE (o_valid=0) and STREAM (o_valid=1).
REQ-015 SHALL accept i_load in IDLE; it then captures all 32 words of i_frame into an internal buffer, clears the position counter n to 0, and enters STREAM on the same edge.
REQ-016 SHALL assert o_valid with word position 0 on o_data in the cycle after acceptance; the load-to-first-word latency is 1 cycle.
REQ-017 SHALL complete a handshake on every rising edge where o_valid and i_ready are both high; a handshake advances n by 1.
REQ-018 SHALL hold o_data, o_index and o_valid stable while o_valid=1 and i_ready=0.
REQ-019 SHALL return to IDLE after the handshake at n==31; n wraps to 0.
REQ-020 SHALL also accept i_load in the same cycle as the n==31 handshake: the new frame is captured, n=0, the state stays STREAM, and there is no bubble.
REQ-021 SHALL refuse i_load in STREAM in any other cycle: the buffer is unchanged and o_drop pulses high in the next cycle.
REQ-022 SHALL drive o_data purely from registered state; i_frame changes after capture SHALL NOT affect output.
REQ-023 SHALL pass word bits through unmodified: no rounding, scaling or sign change.

Reset
REQ-024 SHALL, on RST low and regardless of clock, force state=IDLE, n=0, o_valid=0, o_last=0, o_busy=0, o_drop=0, o_data=0 and o_index=0.
REQ-025 SHALL abandon any frame that is mid-stream when reset asserts; after RST rises, the block SHALL wait in IDLE for a new i_load.
REQ-026 SHALL NOT require buffer contents to be reset.

Configuration
REQ-027 SHALL support the macro FFT_BITREV_EN: when defined, o_data at position n SHALL be buffered word bitrev5(n), e.g. n=1 gives word 16 and n=3 gives word 24.
REQ-028 SHALL, when FFT_BITREV_EN is undefined, output word n at position n (natural order).
REQ-029 SHALL leave o_index, o_last and all handshake timing identical in both builds.

Verification
REQ-030 SHALL cover basic streaming: word k=k*0x00010001, i_load one cycle, i_ready held 1 -> o_valid from the next cycle for exactly 32 cycles; natural build o_data=0x00000000,0x00010001,...,0x001F001F; o_last only on the 32nd; then IDLE.
REQ-031 SHALL cover the bit-reverse build with the same frame -> o_data sequence 0x00000000, 0x00100010, 0x00080008, 0x00180018, ...; o_index counts 0..31.
REQ-032 SHALL cover backpressure: i_ready=0 during positions 5..9 for 3 cycles each -> o_data/o_index frozen while stalled; 32 handshakes total; no word lost or repeated.
REQ-033 SHALL cover load refusal: i_load pulsed at n=10 -> o_drop high for one cycle; remaining words come from the original frame.
REQ-034 SHALL cover back-to-back frames: second i_load coincident with the n==31 handshake -> next cycle o_index=0 with the new frame's word, o_valid continuously 1, o_drop=0.
REQ-035 SHALL cover reset mid-operation: RST low asynchronously at n=17 -> o_valid=0 immediately and all outputs 0; after release and a new i_load, the stream starts at o_index=0.
